decode: RTL

Decode stage of the LC3 pipeline, directly downstream of the Fetch stage. Captures the instruction word returned by instruction memory together with the incremented PC from Fetch, and produces registered control words for the Execute, Memory and Writeback stages. It updates only on the controller's `enable_decode` strobe and otherwise holds its outputs.

---
 rtl/lc3_pkg.sv | 51 +++++
 rtl/decode_ctrl.sv | 87 ++++++++
 rtl/decode.sv | 54 +++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC3 pipeline definitions: opcodes, control-field encodings and
// bit positions inside the Execute control word.
package lc3_pkg;

  typedef enum logic [3:0] {
    OpBr   = 4'h0,
    OpAdd  = 4'h1,
    OpLd   = 4'h2,
    OpSt   = 4'h3,
    OpJsr  = 4'h4,
    OpAnd  = 4'h5,
    OpLdr  = 4'h6,
    OpStr  = 4'h7,
    OpRti  = 4'h8,
    OpNot  = 4'h9,
    OpLdi  = 4'hA,
    OpSti  = 4'hB,
    OpJmp  = 4'hC,
    OpRsv  = 4'hD,
    OpLea  = 4'hE,
    OpTrap = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    AluAdd = 2'b00,
    AluAnd = 2'b01,
    AluNot = 2'b10
  } alu_ctrl_e;

  // Address-adder offset source.
  typedef enum logic [1:0] {
    PcOff11 = 2'b00,
    PcOff9  = 2'b01,
    PcOff6  = 2'b10,
    PcZero  = 2'b11
  } pcsel1_e;

  typedef enum logic [1:0] {
    WbAlu  = 2'b00,
    WbAddr = 2'b01,
    WbMem  = 2'b10
  } wb_sel_e;

  // E_control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
  localparam int unsigned EAluLsb     = 4;
  localparam int unsigned EPcSel1Lsb  = 2;
  localparam int unsigned EPcSel2Bit  = 1;
  localparam int unsigned EOp2SelBit  = 0;
  localparam int unsigned EWidth      = 6;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational LC3 opcode decoder producing Execute/Writeback/Memory
// control words and an illegal-opcode flag.
module decode_ctrl
  import lc3_pkg::*;
(
  input  logic [3:0]        opcode,
  input  logic              imm_flag,
  output logic [EWidth-1:0] e_control,
  output logic [1:0]        w_control,
  output logic              mem_control,
  output logic              illegal_op
);

  alu_ctrl_e alu;
  pcsel1_e   pcsel1;
  logic      pcsel2;
  logic      op2sel;
  wb_sel_e   wb_sel;

  always_comb begin
    alu         = AluAdd;
    pcsel1      = PcOff11;
    pcsel2      = 1'b0;
    op2sel      = 1'b0;
    wb_sel      = WbAlu;
    mem_control = 1'b0;
    illegal_op  = 1'b0;
    case (opcode)
      OpAdd: op2sel = ~imm_flag;
      OpAnd: begin
        alu    = AluAnd;
        op2sel = ~imm_flag;
      end
      OpNot: begin
        alu    = AluNot;
        op2sel = 1'b1;
      end
      OpBr: begin
        pcsel1 = PcOff9;
        pcsel2 = 1'b1;
      end
      OpJmp: pcsel1 = PcZero;
      OpLd: begin
        pcsel1 = PcOff9;
        pcsel2 = 1'b1;
        wb_sel = WbMem;
      end
      OpLdr: begin
        pcsel1 = PcOff6;
        wb_sel = WbMem;
      end
      OpLdi: begin
        pcsel1      = PcOff9;
        pcsel2      = 1'b1;
        wb_sel      = WbMem;
        mem_control = 1'b1;
      end
      OpLea: begin
        pcsel1 = PcOff9;
        pcsel2 = 1'b1;
        wb_sel = WbAddr;
      end
      OpSt: begin
        pcsel1 = PcOff9;
        pcsel2 = 1'b1;
      end
      OpStr: pcsel1 = PcOff6;
      OpSti: begin
        pcsel1      = PcOff9;
        pcsel2      = 1'b1;
        mem_control = 1'b1;
      end
      // Unsupported opcodes: controls stay 0, flag raised.
      default: illegal_op = 1'b1;
    endcase
  end

  always_comb begin
    e_control                       = '0;
    e_control[EAluLsb +: 2]         = alu;
    e_control[EPcSel1Lsb +: 2]      = pcsel1;
    e_control[EPcSel2Bit]           = pcsel2;
    e_control[EOp2SelBit]           = op2sel;
    w_control                       = wb_sel;
  end

endmodule

// File: rtl/decode.sv
// LC3 Decode stage: registers the fetched instruction and PC+1 along with
// the decoded control words, updating only when enable_decode is high.
module decode
  import lc3_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_decode,
  input  logic [WIDTH-1:0] dout,
  input  logic [WIDTH-1:0] npc_in,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] npc_out,
  output logic [5:0]       E_control,
  output logic [1:0]       W_control,
  output logic             Mem_control,
  output logic             illegal_op
);

  logic [EWidth-1:0] e_control_d;
  logic [1:0]        w_control_d;
  logic              mem_control_d;
  logic              illegal_op_d;

  // Decode straight from the memory word so controls line up with IR.
  decode_ctrl u_decode_ctrl (
    .opcode      (dout[15:12]),
    .imm_flag    (dout[5]),
    .e_control   (e_control_d),
    .w_control   (w_control_d),
    .mem_control (mem_control_d),
    .illegal_op  (illegal_op_d)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      IR          <= '0;
      npc_out     <= '0;
      E_control   <= '0;
      W_control   <= '0;
      Mem_control <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (enable_decode) begin
      IR          <= dout;
      npc_out     <= npc_in;
      E_control   <= e_control_d;
      W_control   <= w_control_d;
      Mem_control <= mem_control_d;
      illegal_op  <= illegal_op_d;
    end
  end

endmodule
